decode: RTL and testbench
=========================

Name: decode

Overview:
Instruction decode stage of the rv32 pipeline, directly downstream of fetch.
- Holds the IF/ID register and contains the 32x32 integer register file, immediate generator, control decoder and load-use hazard detector.
- Registers its results into the ID/EX register for execute.
- Resolves JAL early and returns a bubble request and JAL redirect to fetch.

Parameters:
- WORD_WIDTH, 32, datapath/PC width (riscv::WORD_WIDTH)
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch output valid
- if_pc  in  WORD_WIDTH  PC of if_ir
- if_ir  in  32  fetched instruction (rv32i::ir_t)
- flush  in  1  taken branch/JALR from execute; squash ID and ID/EX
- wb_en  in  1  register write enable from writeback
- wb_rd  in  5  writeback destination
- wb_data  in  WORD_WIDTH  writeback data
- bubble  out  1  to fetch: hold PC/IR this cycle
- jal_taken  out  1  JAL in ID; fetch selects jal_tgt
- jal_tgt  out  WORD_WIDTH  IF/ID pc + J-immediate
- id_valid  out  1  ID/EX holds a real instruction
- id_pc  out  WORD_WIDTH
- id_rs1, id_rs2, id_rd  out  5 each  register indices (for EX forwarding)
- id_rs1_data, id_rs2_data  out  WORD_WIDTH
- id_imm  out  WORD_WIDTH  sign-extended immediate
- id_opcode  out  7; id_funct3  out  3; id_funct7_5  out  1
- id_reg_wr, id_mem_rd, id_mem_wr, id_illegal  out  1 each

Behaviour:
- Reset (sync, active-high): IF/ID valid=0; all ID/EX outputs 0; bubble=0; jal_taken=0. Register file contents are not reset; x0 always reads 0.
- Latency: instruction on if_* at edge N enters IF/ID. It is decoded combinationally during the following cycle and appears on id_* after edge N+1 (two edges total).
- IF/ID update priority, highest first:
  - flush: valid←0.
  - bubble: hold.
  - jal_taken: valid←0; the sequential wrong-path instruction is squashed, 1-cycle penalty.
  - otherwise: load if_valid/if_pc/if_ir.
- ID/EX update:
  - flush or bubble or IF/ID invalid: id_valid←0 and id_reg_wr/id_mem_rd/id_mem_wr/id_illegal←0. Other fields are don't-care.
  - otherwise: capture decode results.
- Register file: 32 entries, combinational read of IF/ID rs1/rs2, write on clk when wb_en && wb_rd≠0.
  - Write-first bypass: when wb_en && wb_rd==rs && rs≠0, read returns wb_data in the same cycle.
  - rs==0 returns 0 regardless of writeback.
- Immediates, sign-extended from ir[31]:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC; low 12 bits 0
  - J: JAL, bit0=0
  - all other opcodes: 0
- Control decode:
  - LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP: id_reg_wr=1 unless rd==0.
  - LOAD: id_mem_rd=1.
  - STORE: id_mem_wr=1.
  - MISC-MEM and SYSTEM: legal no-ops, all enables 0.
  - Any other opcode, or ir[1:0]≠2'b11: id_illegal=1, all enables 0.
- Source usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
- Load-use hazard: bubble=1 (combinational) iff all of the following hold:
  - IF/ID valid, and
  - id_valid && id_mem_rd && id_rd≠0, and
  - a used source of the IF/ID instruction equals id_rd.
  - Exception: flush forces bubble=0.
  - Each load-use hazard lasts exactly one cycle, because the next cycle's ID/EX is a bubble.
- jal_taken = IF/ID valid && opcode==JAL && !flush && !bubble.
- jal_tgt = IF/ID pc + J-imm, modulo 2^WORD_WIDTH (wraps, no overflow flag).
- Reset asserted mid-stream: overrides everything; the next cycle shows reset values.

Test Plan:
1. Reset, then ADDI x1,x0,5 (0x00500093) at pc 0x0 -> two edges later id_valid=1, id_imm=5, id_rd=1, id_reg_wr=1, id_rs1_data=0, id_pc=0.
2. ADD x3,x2,x2 (0x002101B3) in IF/ID with wb_en=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle -> id_rs1_data=id_rs2_data=0xDEADBEEF. A subsequent read with wb_en=0 still returns 0xDEADBEEF.
3. LW x5,0(x1) (0x0000A283) then ADD x6,x5,x0 (0x00028333) -> bubble=1 for exactly one cycle, one id_valid=0 slot, then ADD issues with id_rs1=5. Repeat with rd=x0: no bubble.
4. JAL x1,+8 (0x008000EF) at pc 0x100 -> jal_taken=1, jal_tgt=0x108. The next IF/ID capture is squashed (one id_valid=0 slot); JAL itself reaches ID/EX with id_imm=8, id_reg_wr=1.
5. BEQ x0,x0,-4 (0xFE000EE3) -> id_imm=0xFFFFFFFC, id_reg_wr=0. Opcode 0x7F -> id_illegal=1 with all enables 0.
6. flush asserted while a load-use hazard is pending -> bubble=0, IF/ID and ID/EX both invalid next cycle. Reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode.sv
// RV32I instruction decode stage: IF/ID register, 32x32 register file, immediate and
// control decode, load-use hazard detection, early JAL resolution and the ID/EX register.
module decode #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_valid,
    input  logic [WORD_WIDTH-1:0]     if_pc,
    input  logic [31:0]               if_ir,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [WORD_WIDTH-1:0]     wb_data,
    output logic                      bubble,
    output logic                      jal_taken,
    output logic [WORD_WIDTH-1:0]     jal_tgt,
    output logic                      id_valid,
    output logic [WORD_WIDTH-1:0]     id_pc,
    output logic [REG_ADDR_WIDTH-1:0] id_rs1,
    output logic [REG_ADDR_WIDTH-1:0] id_rs2,
    output logic [REG_ADDR_WIDTH-1:0] id_rd,
    output logic [WORD_WIDTH-1:0]     id_rs1_data,
    output logic [WORD_WIDTH-1:0]     id_rs2_data,
    output logic [WORD_WIDTH-1:0]     id_imm,
    output logic [6:0]                id_opcode,
    output logic [2:0]                id_funct3,
    output logic                      id_funct7_5,
    output logic                      id_reg_wr,
    output logic                      id_mem_rd,
    output logic                      id_mem_wr,
    output logic                      id_illegal
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_kind_e;

    typedef struct packed {
        logic                      valid;
        logic [WORD_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [WORD_WIDTH-1:0]     rs1_data;
        logic [WORD_WIDTH-1:0]     rs2_data;
        logic [WORD_WIDTH-1:0]     imm;
        logic [6:0]                opcode;
        logic [2:0]                funct3;
        logic                      funct7_5;
        logic                      reg_wr;
        logic                      mem_rd;
        logic                      mem_wr;
        logic                      illegal;
    } idex_t;

    // Immediates are assembled at 32 bits and then sign-extended to the datapath width.
    function automatic logic [WORD_WIDTH-1:0] imm_gen(input logic [31:0] ir, input imm_kind_e kind);
        logic [31:0] imm32;
        case (kind)
            IMM_I:   imm32 = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm32 = {ir[31:12], 12'h000};
            IMM_J:   imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm32 = 32'h0000_0000;
        endcase
        return WORD_WIDTH'($signed(imm32));
    endfunction

    logic                      ifid_valid_q, ifid_valid_d;
    logic [WORD_WIDTH-1:0]     ifid_pc_q, ifid_pc_d;
    logic [31:0]               ifid_ir_q, ifid_ir_d;
    logic [WORD_WIDTH-1:0]     rf_q [NUM_REGS];
    idex_t                     idex_q, idex_d;

    logic [6:0]                opcode_s;
    logic [REG_ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
    logic [WORD_WIDTH-1:0]     rs1_data_s, rs2_data_s;
    logic                      writes_rd_s, dec_reg_wr_s, dec_mem_rd_s, dec_mem_wr_s, dec_illegal_s;
    logic                      use_rs1_s, use_rs2_s;
    imm_kind_e                 imm_kind_s;
    logic                      hazard_s, bubble_s, jal_taken_s, idex_kill_s;

    assign opcode_s = ifid_ir_q[6:0];
    assign rd_s     = ifid_ir_q[7 +: REG_ADDR_WIDTH];
    assign rs1_s    = ifid_ir_q[15 +: REG_ADDR_WIDTH];
    assign rs2_s    = ifid_ir_q[20 +: REG_ADDR_WIDTH];

    // Register file read with write-first bypass from writeback; x0 is hardwired to zero.
    always_comb begin
        rs1_data_s = '0;
        rs2_data_s = '0;
        if (rs1_s == '0) begin
            rs1_data_s = '0;
        end else if (wb_en && (wb_rd == rs1_s)) begin
            rs1_data_s = wb_data;
        end else begin
            rs1_data_s = rf_q[rs1_s];
        end
        if (rs2_s == '0) begin
            rs2_data_s = '0;
        end else if (wb_en && (wb_rd == rs2_s)) begin
            rs2_data_s = wb_data;
        end else begin
            rs2_data_s = rf_q[rs2_s];
        end
    end

    // Control decode: enables, immediate format and which sources the instruction reads.
    always_comb begin
        writes_rd_s   = 1'b0;
        dec_mem_rd_s  = 1'b0;
        dec_mem_wr_s  = 1'b0;
        dec_illegal_s = 1'b0;
        use_rs1_s     = 1'b0;
        use_rs2_s     = 1'b0;
        imm_kind_s    = IMM_NONE;
        if (ifid_ir_q[1:0] != 2'b11) begin
            dec_illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_LUI, OPC_AUIPC: begin
                    writes_rd_s = 1'b1;
                    imm_kind_s  = IMM_U;
                end
                OPC_JAL: begin
                    writes_rd_s = 1'b1;
                    imm_kind_s  = IMM_J;
                end
                OPC_JALR: begin
                    writes_rd_s = 1'b1;
                    use_rs1_s   = 1'b1;
                    imm_kind_s  = IMM_I;
                end
                OPC_BRANCH: begin
                    use_rs1_s  = 1'b1;
                    use_rs2_s  = 1'b1;
                    imm_kind_s = IMM_B;
                end
                OPC_LOAD: begin
                    writes_rd_s  = 1'b1;
                    dec_mem_rd_s = 1'b1;
                    use_rs1_s    = 1'b1;
                    imm_kind_s   = IMM_I;
                end
                OPC_STORE: begin
                    dec_mem_wr_s = 1'b1;
                    use_rs1_s    = 1'b1;
                    use_rs2_s    = 1'b1;
                    imm_kind_s   = IMM_S;
                end
                OPC_OP_IMM: begin
                    writes_rd_s = 1'b1;
                    use_rs1_s   = 1'b1;
                    imm_kind_s  = IMM_I;
                end
                OPC_OP: begin
                    writes_rd_s = 1'b1;
                    use_rs1_s   = 1'b1;
                    use_rs2_s   = 1'b1;
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                    writes_rd_s = 1'b0;
                end
                default: begin
                    dec_illegal_s = 1'b1;
                end
            endcase
        end
    end

    assign dec_reg_wr_s = writes_rd_s && (rd_s != '0);

    // A load in ID/EX whose rd feeds a used source of IF/ID must stall one cycle.
    assign hazard_s = ifid_valid_q && idex_q.valid && idex_q.mem_rd && (idex_q.rd != '0) &&
                      ((use_rs1_s && (rs1_s == idex_q.rd)) || (use_rs2_s && (rs2_s == idex_q.rd)));
    assign bubble_s    = hazard_s && !flush;
    assign jal_taken_s = ifid_valid_q && (opcode_s == OPC_JAL) && !flush && !bubble_s;
    assign idex_kill_s = flush || bubble_s || !ifid_valid_q;

    assign bubble    = bubble_s;
    assign jal_taken = jal_taken_s;
    assign jal_tgt   = ifid_pc_q + imm_gen(ifid_ir_q, IMM_J);

    // IF/ID next state: flush beats stall, stall beats the JAL wrong-path squash.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (bubble_s) begin
            ifid_valid_d = ifid_valid_q;
        end else if (jal_taken_s) begin
            ifid_valid_d = 1'b0;
        end else begin
            ifid_valid_d = if_valid;
            ifid_pc_d    = if_pc;
            ifid_ir_d    = if_ir;
        end
    end

    // ID/EX next state: a killed slot only needs its valid and enables cleared.
    always_comb begin
        idex_d = idex_q;
        if (idex_kill_s) begin
            idex_d.valid   = 1'b0;
            idex_d.reg_wr  = 1'b0;
            idex_d.mem_rd  = 1'b0;
            idex_d.mem_wr  = 1'b0;
            idex_d.illegal = 1'b0;
        end else begin
            idex_d.valid    = 1'b1;
            idex_d.pc       = ifid_pc_q;
            idex_d.rs1      = rs1_s;
            idex_d.rs2      = rs2_s;
            idex_d.rd       = rd_s;
            idex_d.rs1_data = rs1_data_s;
            idex_d.rs2_data = rs2_data_s;
            idex_d.imm      = imm_gen(ifid_ir_q, imm_kind_s);
            idex_d.opcode   = opcode_s;
            idex_d.funct3   = ifid_ir_q[14:12];
            idex_d.funct7_5 = ifid_ir_q[30];
            idex_d.reg_wr   = dec_reg_wr_s;
            idex_d.mem_rd   = dec_mem_rd_s;
            idex_d.mem_wr   = dec_mem_wr_s;
            idex_d.illegal  = dec_illegal_s;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_ir_q    <= 32'h0000_0000;
            idex_q       <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
            idex_q       <= idex_d;
        end
    end

    // Register file write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wb_en && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_data;
        end else begin
            rf_q[0] <= '0;
        end
    end

    assign id_valid    = idex_q.valid;
    assign id_pc       = idex_q.pc;
    assign id_rs1      = idex_q.rs1;
    assign id_rs2      = idex_q.rs2;
    assign id_rd       = idex_q.rd;
    assign id_rs1_data = idex_q.rs1_data;
    assign id_rs2_data = idex_q.rs2_data;
    assign id_imm      = idex_q.imm;
    assign id_opcode   = idex_q.opcode;
    assign id_funct3   = idex_q.funct3;
    assign id_funct7_5 = idex_q.funct7_5;
    assign id_reg_wr   = idex_q.reg_wr;
    assign id_mem_rd   = idex_q.mem_rd;
    assign id_mem_wr   = idex_q.mem_wr;
    assign id_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a transaction-level model predicts each ID/EX slot,
// a monitor compares the DUT's ID/EX output against the queued predictions.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset, if_valid, flush, wb_en;
    logic [31:0] if_pc, if_ir, wb_data;
    logic [4:0]  wb_rd;
    logic        bubble, jal_taken, id_valid, id_funct7_5, id_reg_wr, id_mem_rd, id_mem_wr, id_illegal;
    logic [31:0] jal_tgt, id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;

    always #5 clk = ~clk;

    decode #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .bubble(bubble), .jal_taken(jal_taken), .jal_tgt(jal_tgt),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic        full;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        rw, mr, mw, ill;
    } rec_t;

    localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    rec_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_if_v, m_ex_v, m_ex_mr;
    logic [31:0] m_if_pc, m_if_ir;
    logic [4:0]  m_ex_rd;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] sx(input int unsigned nbits, input logic [31:0] v);
        return v[nbits-1] ? (v | (32'hFFFF_FFFF << nbits)) : v;
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] ir);
        return sx(21, {11'h000, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ir);
        return ir[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        return ir[6:0] inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic rec_t ref_decode(input logic [31:0] pc, input logic [31:0] ir);
        rec_t r;
        logic wr;
        r = '0;
        wr = 1'b0;
        r.valid = 1'b1; r.full = 1'b1; r.pc = pc;
        r.rs1 = ir[19:15]; r.rs2 = ir[24:20]; r.rd = ir[11:7];
        r.d1 = mread(ir[19:15]); r.d2 = mread(ir[24:20]);
        r.opc = ir[6:0]; r.f3 = ir[14:12]; r.f7 = ir[30];
        if (ir[1:0] != 2'b11) r.ill = 1'b1;
        else case (ir[6:0])
            7'h37, 7'h17: begin wr = 1'b1; r.imm = {ir[31:12], 12'h000}; end
            7'h6F: begin wr = 1'b1; r.imm = j_imm(ir); end
            7'h67, 7'h13: begin wr = 1'b1; r.imm = sx(12, {20'h0, ir[31:20]}); end
            7'h03: begin wr = 1'b1; r.mr = 1'b1; r.imm = sx(12, {20'h0, ir[31:20]}); end
            7'h23: begin r.mw = 1'b1; r.imm = sx(12, {20'h0, ir[31:25], ir[11:7]}); end
            7'h63: r.imm = sx(13, {19'h0, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
            7'h33: wr = 1'b1;
            7'h0F, 7'h73: wr = 1'b0;
            default: r.ill = 1'b1;
        endcase
        r.rw = wr && (ir[11:7] != 5'd0);
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check fetch-side outputs, predict the next ID/EX slot.
    task automatic step(input logic rst, input logic iv, input logic [31:0] pc, input logic [31:0] ir,
                        input logic fl, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        rec_t r;
        logic bub, jal;
        @(posedge clk);
        #2;
        reset = rst; if_valid = iv; if_pc = pc; if_ir = ir; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        if (rst) begin
            r = '0; r.full = 1'b1;
            sb_q.push_back(r);
            m_if_v = 1'b0; m_ex_v = 1'b0; m_ex_mr = 1'b0; m_ex_rd = 5'd0;
        end else begin
            bub = !fl && m_if_v && m_ex_v && m_ex_mr && (m_ex_rd != 5'd0) &&
                  ((uses_rs1(m_if_ir) && m_if_ir[19:15] == m_ex_rd) ||
                   (uses_rs2(m_if_ir) && m_if_ir[24:20] == m_ex_rd));
            jal = m_if_v && (m_if_ir[6:0] == 7'h6F) && !fl && !bub;
            check32("bubble", {31'h0, bubble}, {31'h0, bub});
            check32("jal_taken", {31'h0, jal_taken}, {31'h0, jal});
            if (jal) check32("jal_tgt", jal_tgt, m_if_pc + j_imm(m_if_ir));
            if (fl || bub || !m_if_v) begin
                r = '0;
                m_ex_v = 1'b0; m_ex_mr = 1'b0;
            end else begin
                r = ref_decode(m_if_pc, m_if_ir);
                m_ex_v = 1'b1; m_ex_mr = r.mr; m_ex_rd = r.rd;
            end
            sb_q.push_back(r);
            if (fl || (jal && !bub)) m_if_v = 1'b0;
            else if (!bub) begin m_if_v = iv; m_if_pc = pc; m_if_ir = ir; end
        end
        if (we && wr != 5'd0) m_regs[wr] = wd;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ir);
        step(1'b0, 1'b1, pc, ir, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        int unsigned k;
        ir = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) ir[6:0] = OPCS[k];
        else if (k == 11) ir[1:0] = 2'($urandom_range(0, 2));
        ir[11:10] = 2'b00; ir[19:18] = 2'b00; ir[24:23] = 2'b00;
        return ir;
    endfunction

    // Monitor: every cycle the DUT's ID/EX slot is compared with the oldest prediction.
    initial begin
        rec_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                a.valid = id_valid; a.full = e.full; a.pc = id_pc;
                a.rs1 = id_rs1; a.rs2 = id_rs2; a.rd = id_rd;
                a.d1 = id_rs1_data; a.d2 = id_rs2_data; a.imm = id_imm;
                a.opc = id_opcode; a.f3 = id_funct3; a.f7 = id_funct7_5;
                a.rw = id_reg_wr; a.mr = id_mem_rd; a.mw = id_mem_wr; a.ill = id_illegal;
                checks++;
                if (e.valid || e.full) begin
                    if (a !== e) begin
                        errors++;
                        $display("FAIL idex: got %h expected %h", a, e);
                    end
                end else if ({a.valid, a.rw, a.mr, a.mw, a.ill} !== 5'b00000) begin
                    errors++;
                    $display("FAIL idex_kill: got %b expected 00000", {a.valid, a.rw, a.mr, a.mw, a.ill});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0; if_ir = 32'h0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        m_if_v = 1'b0; m_if_pc = 32'h0; m_if_ir = 32'h0; m_ex_v = 1'b0; m_ex_mr = 1'b0; m_ex_rd = 5'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("reset_id_valid", {31'h0, id_valid}, 32'h0);
        for (int i = 1; i < 32; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'(i), $urandom);

        // ADDI x1,x0,5 reaches ID/EX two edges after capture
        issue(32'h0, 32'h00500093); idle(); idle();
        check32("addi_valid", {31'h0, id_valid}, 32'h1);
        check32("addi_imm", id_imm, 32'h5);
        check32("addi_rd", {27'h0, id_rd}, 32'h1);
        check32("addi_reg_wr", {31'h0, id_reg_wr}, 32'h1);
        check32("addi_rs1_data", id_rs1_data, 32'h0);
        check32("addi_pc", id_pc, 32'h0);

        // ADD x3,x2,x2 with same-cycle writeback of x2, then a plain re-read
        issue(32'h4, 32'h002101B3);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
        issue(32'h8, 32'h002101B3);
        check32("bypass_rs1", id_rs1_data, 32'hDEADBEEF);
        check32("bypass_rs2", id_rs2_data, 32'hDEADBEEF);
        idle(); idle();
        check32("reread_rs1", id_rs1_data, 32'hDEADBEEF);

        // LW x5 then ADD x6,x5,x0: one stall slot
        issue(32'h10, 32'h0000A283); issue(32'h14, 32'h00028333); idle();
        check32("lu_bubble", {31'h0, bubble}, 32'h1);
        idle();
        check32("lu_slot", {31'h0, id_valid}, 32'h0);
        check32("lu_bubble_once", {31'h0, bubble}, 32'h0);
        idle();
        check32("lu_add_rs1", {27'h0, id_rs1}, 32'h5);
        issue(32'h18, 32'h0000A003); issue(32'h1C, 32'h00000333); idle();
        check32("lu_x0_no_bubble", {31'h0, bubble}, 32'h0);
        idle(); idle();

        // JAL x1,+8 at 0x100
        issue(32'h100, 32'h008000EF); issue(32'h104, 32'h00100113);
        check32("jal_taken_dir", {31'h0, jal_taken}, 32'h1);
        check32("jal_tgt_dir", jal_tgt, 32'h108);
        issue(32'h108, 32'h00700393);
        check32("jal_imm", id_imm, 32'h8);
        check32("jal_reg_wr", {31'h0, id_reg_wr}, 32'h1);
        idle();
        check32("jal_squash", {31'h0, id_valid}, 32'h0);
        idle();
        check32("jal_target_pc", id_pc, 32'h108);

        // BEQ -4 and an illegal opcode
        issue(32'h200, 32'hFE000EE3); issue(32'h204, 32'h0000007F); idle();
        check32("beq_imm", id_imm, 32'hFFFFFFFC);
        check32("beq_reg_wr", {31'h0, id_reg_wr}, 32'h0);
        idle();
        check32("illegal", {28'h0, id_illegal, id_reg_wr, id_mem_rd, id_mem_wr}, 32'h8);

        // flush during a pending load-use hazard, then reset mid-stream
        issue(32'h300, 32'h0000A283); issue(32'h304, 32'h00028333);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        check32("flush_kills_bubble", {31'h0, bubble}, 32'h0);
        idle();
        check32("flush_idex", {31'h0, id_valid}, 32'h0);
        idle();
        check32("flush_ifid", {31'h0, id_valid}, 32'h0);
        issue(32'h400, 32'h00500093); issue(32'h404, 32'h00600113);
        step(1'b1, 1'b1, 32'h408, 32'h00700193, 1'b0, 1'b0, 5'd0, 32'h0);
        idle();
        check32("rst_mid_valid", {31'h0, id_valid}, 32'h0);
        check32("rst_mid_pc", id_pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic rst_r, we_r;
            rst_r = ($urandom_range(0, 149) == 0);
            we_r = !rst_r && ($urandom_range(0, 1) == 1);
            step(rst_r, ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, rand_ir(),
                 ($urandom_range(0, 11) == 0), we_r, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(); idle();
        @(posedge clk);
        #2;
        check32("scoreboard_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
